// File: rtl/mvm_pkg.sv
// mvm_pkg -- shared constants for the MVM sequencing controller.
//   State encodings (IDLE/LOAD/COMPUTE/OUTPUT), default matrix dimension,
//   default LOAD timeout, and the index-width helper used by every port
//   that carries a row/column tag.
package mvm_pkg;

  localparam int MVM_N_DEF       = 4;
  localparam int MVM_TIMEOUT_DEF = 1024;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_LOAD    = 2'd1;
  localparam state_t ST_COMPUTE = 2'd2;
  localparam state_t ST_OUTPUT  = 2'd3;

  // Index width for an N-entry dimension; never below one bit so N=1 still has a port.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mvm_idx_counter.sv
// mvm_idx_counter -- nested row/col index counter that wraps at N-1.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     clr_i         force row=col=0 (highest priority after reset)
//     step_i        nested step: col advances, row advances when col wraps
//     row_step_i    row-only step (col untouched)
//     row_o, col_o  current indices (registered)
//     col_last_o    col == N-1
//     row_last_o    row == N-1
//     last_o        (row,col) == (N-1,N-1)
//   Wrapping compares against N-1 rather than relying on overflow, so
//   non-power-of-two N sweeps exactly N values per dimension.
module mvm_idx_counter
  import mvm_pkg::*;
#(
  parameter  int N  = MVM_N_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          step_i,
  input  logic          row_step_i,
  output logic [IW-1:0] row_o,
  output logic [IW-1:0] col_o,
  output logic          col_last_o,
  output logic          row_last_o,
  output logic          last_o
);

  localparam logic [IW-1:0] IdxLast = IW'(N - 1);
  localparam logic [IW-1:0] IdxZero = IW'(0);
  localparam logic [IW-1:0] IdxOne  = IW'(1);

  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] col_q, col_d;

  assign col_last_o = (col_q == IdxLast);
  assign row_last_o = (row_q == IdxLast);
  assign last_o     = col_last_o & row_last_o;
  assign row_o      = row_q;
  assign col_o      = col_q;

  // Next-index selection: clear, nested step, row-only step, or hold.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = IdxZero;
      col_d = IdxZero;
    end else if (step_i) begin
      if (col_last_o) begin
        col_d = IdxZero;
        row_d = row_last_o ? IdxZero : (row_q + IdxOne);
      end else begin
        col_d = col_q + IdxOne;
      end
    end else if (row_step_i) begin
      row_d = row_last_o ? IdxZero : (row_q + IdxOne);
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= IdxZero;
      col_q <= IdxZero;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/mvm_seq_ctrl.sv
// mvm_seq_ctrl -- sequencing controller for the MVM accelerator datapath.
//   Walks IDLE -> LOAD -> COMPUTE -> OUTPUT -> IDLE while start is held.
//   LOAD accepts tagged host beats and re-issues them as one-cycle-late
//   datapath writes; COMPUTE sweeps (row,col) over N*N MAC steps; OUTPUT
//   presents result indices 0..N-1 under a valid/ready handshake.
//   No element data passes through this block.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     start                         session enable (level); low forces IDLE
//     host_valid/host_ready         host beat handshake (ready only in LOAD)
//     host_vec/host_row/host_col    beat tags; host_last ends the load phase
//     dp_wr_en/vec/row/col          datapath element write (registered)
//     dp_mac_en/dp_clr/dp_row/dp_col MAC sweep controls
//     out_valid/out_ready/out_idx   result streaming handshake
//     busy                          state != IDLE
//     err                           sticky LOAD timeout flag
//   Optional feature: define MVM_TIMEOUT_EN to abort a LOAD that sees no
//   accepted beat for TIMEOUT_CYC consecutive cycles (err set, back to IDLE).
//   Without it err is tied low and LOAD waits indefinitely.
module mvm_seq_ctrl
  import mvm_pkg::*;
#(
  parameter  int N           = MVM_N_DEF,
  parameter  int TIMEOUT_CYC = MVM_TIMEOUT_DEF,
  localparam int IW          = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          host_vec,
  input  logic [IW-1:0] host_row,
  input  logic [IW-1:0] host_col,
  input  logic          host_last,
  output logic          dp_wr_en,
  output logic          dp_wr_vec,
  output logic [IW-1:0] dp_wr_row,
  output logic [IW-1:0] dp_wr_col,
  output logic          dp_mac_en,
  output logic          dp_clr,
  output logic [IW-1:0] dp_row,
  output logic [IW-1:0] dp_col,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic          busy,
  output logic          err
);

  state_t        state_q, state_d;
  logic          host_ready_q, host_ready_d;
  logic          wr_en_q, wr_en_d;
  logic          wr_vec_q, wr_vec_d;
  logic [IW-1:0] wr_row_q, wr_row_d;
  logic [IW-1:0] wr_col_q, wr_col_d;
  logic          mac_en_q, mac_en_d;
  logic          clr_q, clr_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  logic          accept_s;
  logic          out_take_s;
  logic          timeout_s;
  logic          cnt_clr_s, cnt_step_s, cnt_row_step_s;
  logic [IW-1:0] cnt_row_s, cnt_col_s;
  logic          cnt_col_last_s, cnt_row_last_s, cnt_last_s;

  // host_ready_q is only ever high while in LOAD, so this also implies LOAD.
  assign accept_s   = host_valid & host_ready_q;
  assign out_take_s = out_valid_q & out_ready;

  // One counter serves both phases: nested sweep in COMPUTE, row-only
  // stepping as the result index in OUTPUT. The final COMPUTE step wraps
  // it back to (0,0), so OUTPUT starts at index 0 without an extra clear.
  mvm_idx_counter #(.N(N)) u_idx (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr_s),
    .step_i     (cnt_step_s),
    .row_step_i (cnt_row_step_s),
    .row_o      (cnt_row_s),
    .col_o      (cnt_col_s),
    .col_last_o (cnt_col_last_s),
    .row_last_o (cnt_row_last_s),
    .last_o     (cnt_last_s)
  );

  // Phase sequencing and counter control; start low overrides every state.
  always_comb begin
    state_d        = state_q;
    cnt_clr_s      = 1'b0;
    cnt_step_s     = 1'b0;
    cnt_row_step_s = 1'b0;
    if (!start) begin
      state_d   = ST_IDLE;
      cnt_clr_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_LOAD;
          cnt_clr_s = 1'b1;
        end
        ST_LOAD: begin
          cnt_clr_s = 1'b1;
          if (accept_s && host_last) begin
            state_d = ST_COMPUTE;
          end else if (timeout_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_COMPUTE: begin
          cnt_step_s = 1'b1;
          state_d    = cnt_last_s ? ST_OUTPUT : ST_COMPUTE;
        end
        ST_OUTPUT: begin
          if (out_take_s) begin
            cnt_row_step_s = 1'b1;
            state_d        = cnt_row_last_s ? ST_IDLE : ST_OUTPUT;
          end else begin
            state_d = ST_OUTPUT;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          cnt_clr_s = 1'b1;
        end
      endcase
    end
  end

  // Registered-output next values, derived from the next state so each
  // strobe lines up with the cycle its state is current.
  always_comb begin
    host_ready_d = (state_d == ST_LOAD);
    wr_en_d      = accept_s & start;
    wr_vec_d     = wr_vec_q;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    if (accept_s) begin
      wr_vec_d = host_vec;
      wr_row_d = host_row;
      wr_col_d = host_col;
    end else begin
      wr_vec_d = wr_vec_q;
      wr_row_d = wr_row_q;
      wr_col_d = wr_col_q;
    end
    mac_en_d = (state_d == ST_COMPUTE);
    // Column is 0 next cycle either on COMPUTE entry or when it wraps.
    clr_d       = (state_d == ST_COMPUTE) &
                  ((state_q != ST_COMPUTE) | cnt_col_last_s);
    out_valid_d = (state_d == ST_OUTPUT);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      host_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_vec_q     <= 1'b0;
      wr_row_q     <= {IW{1'b0}};
      wr_col_q     <= {IW{1'b0}};
      mac_en_q     <= 1'b0;
      clr_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      host_ready_q <= host_ready_d;
      wr_en_q      <= wr_en_d;
      wr_vec_q     <= wr_vec_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      mac_en_q     <= mac_en_d;
      clr_q        <= clr_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

`ifdef MVM_TIMEOUT_EN
  localparam int            TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] ToLast = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] ToOne  = TW'(1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_q, err_d;

  // Idle-beat counter: runs only while LOAD persists, reset by any accept.
  always_comb begin
    timeout_s = (state_q == ST_LOAD) & ~accept_s & (to_cnt_q == ToLast);
    if ((state_q == ST_LOAD) && (state_d == ST_LOAD)) begin
      to_cnt_d = accept_s ? {TW{1'b0}} : (to_cnt_q + ToOne);
    end else begin
      to_cnt_d = {TW{1'b0}};
    end
    if ((state_q == ST_IDLE) && (state_d == ST_LOAD)) begin
      err_d = 1'b0;
    end else if (start && timeout_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= {TW{1'b0}};
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  assign host_ready = host_ready_q;
  assign dp_wr_en   = wr_en_q;
  assign dp_wr_vec  = wr_vec_q;
  assign dp_wr_row  = wr_row_q;
  assign dp_wr_col  = wr_col_q;
  assign dp_mac_en  = mac_en_q;
  assign dp_clr     = clr_q;
  assign dp_row     = cnt_row_s;
  assign dp_col     = cnt_col_s;
  assign out_valid  = out_valid_q;
  assign out_idx    = cnt_row_s;
  assign busy       = busy_q;

endmodule
